// File: rtl/glm_inv_pkg.sv
// Shared constants for the masked PRINCE inverse S-box.
// The ANF of the table is derived at elaboration time.
package glm_inv_pkg;

    localparam int LANE_W = 4;
    localparam int NIBBLES_DEF = 16;

    // nibble i of the word holds INV(i)
    localparam logic [63:0] INV_TBL = 64'h1CE5_046A_98DF_237B;

    typedef enum logic [1:0] {
        DOM_00,
        DOM_01,
        DOM_10,
        DOM_11
    } dom_e;

    // bit 16*j+m: coefficient of monomial m in output bit j
    function automatic logic [63:0] anf_of(input logic [63:0] tbl);
        logic [15:0] a;
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            for (int m = 0; m < 16; m++) a[m] = tbl[4*m+j];
            for (int i = 0; i < 4; i++) begin
                for (int m = 0; m < 16; m++) begin
                    if (((m >> i) & 1) == 1) a[m] = a[m] ^ a[m ^ (1 << i)];
                end
            end
            r[16*j +: 16] = a;
        end
        return r;
    endfunction

    localparam logic [63:0] INV_ANF = anf_of(INV_TBL);

endpackage

// File: rtl/glm_inv_sbox_d1_eval.sv
// One share-domain term of the masked inverse S-box; purely combinational.
// Only distinct-bit products of the two shares are formed.
module inv_domain_eval
    import glm_inv_pkg::*;
#(
    parameter dom_e DOM = DOM_00
) (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] rnd,
    output logic [3:0] t
);

    localparam bit CROSS = (DOM == DOM_01) || (DOM == DOM_10);
    localparam bit KEEP_CONST = (DOM == DOM_00);

    // Cross domains take the splits whose a-part owns the lowest monomial bit,
    // so 01 and 10 together cover every mixed split exactly once.
    function automatic logic [3:0] eval(input logic [3:0] sa, input logic [3:0] sb);
        logic [3:0] acc, mm, uu, vv, lo;
        logic p, take;
        acc = '0;
        for (int m = 0; m < 16; m++) begin
            for (int u = 0; u < 16; u++) begin
                mm = 4'(m);
                uu = 4'(u);
                vv = mm ^ uu;
                lo = mm & (~mm + 4'd1);
                if (CROSS)
                    take = ((uu & ~mm) == 4'd0) && (uu != 4'd0)
                        && (vv != 4'd0) && ((uu & lo) != 4'd0);
                else
                    take = (uu == mm) && (KEEP_CONST || (mm != 4'd0));
                if (take) begin
                    p = (&(sa | ~uu)) & (&(sb | ~vv));
                    for (int j = 0; j < 4; j++) begin
                        if (INV_ANF[16*j+m]) acc[j] = acc[j] ^ p;
                    end
                end
            end
        end
        return acc;
    endfunction

    assign t = eval(a, b) ^ (CROSS ? rnd : 4'h0);

endmodule

// File: rtl/glm_inv_sbox_d1.sv
// Two-share, two-stage masked PRINCE inverse S-box over NIBBLES lanes.
// Stage 1 holds the four domain terms, stage 2 the compressed shares.
module glm_inv_sbox_d1
    import glm_inv_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*NIBBLES-1:0] in_s0,
    input  logic [LANE_W*NIBBLES-1:0] in_s1,
    input  logic [LANE_W*NIBBLES-1:0] rnd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*NIBBLES-1:0] out_s0,
    output logic [LANE_W*NIBBLES-1:0] out_s1
);

    localparam int W = LANE_W * NIBBLES;

    logic advance;
    logic v1, v2;
    logic [W-1:0] t00, t01, t10, t11;
    logic [W-1:0] d00, d01, d10, d11;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_lane
        inv_domain_eval #(.DOM(DOM_00)) u_d00 (
            .a(in_s0[LANE_W*g +: LANE_W]), .b(in_s0[LANE_W*g +: LANE_W]),
            .rnd(rnd[LANE_W*g +: LANE_W]), .t(t00[LANE_W*g +: LANE_W])
        );
        inv_domain_eval #(.DOM(DOM_01)) u_d01 (
            .a(in_s0[LANE_W*g +: LANE_W]), .b(in_s1[LANE_W*g +: LANE_W]),
            .rnd(rnd[LANE_W*g +: LANE_W]), .t(t01[LANE_W*g +: LANE_W])
        );
        inv_domain_eval #(.DOM(DOM_10)) u_d10 (
            .a(in_s1[LANE_W*g +: LANE_W]), .b(in_s0[LANE_W*g +: LANE_W]),
            .rnd(rnd[LANE_W*g +: LANE_W]), .t(t10[LANE_W*g +: LANE_W])
        );
        inv_domain_eval #(.DOM(DOM_11)) u_d11 (
            .a(in_s1[LANE_W*g +: LANE_W]), .b(in_s1[LANE_W*g +: LANE_W]),
            .rnd(rnd[LANE_W*g +: LANE_W]), .t(t11[LANE_W*g +: LANE_W])
        );
    end

    assign advance   = !v2 || out_ready;
    assign in_ready  = advance;
    assign out_valid = v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            d00    <= '0;
            d01    <= '0;
            d10    <= '0;
            d11    <= '0;
            out_s0 <= '0;
            out_s1 <= '0;
        end else if (advance) begin
            v1     <= in_valid;
            d00    <= in_valid ? t00 : '0;
            d01    <= in_valid ? t01 : '0;
            d10    <= in_valid ? t10 : '0;
            d11    <= in_valid ? t11 : '0;
            v2     <= v1;
            out_s0 <= d00 ^ d01;
            out_s1 <= d10 ^ d11;
        end
    end

endmodule
